sha_1_pad: RTL



---
 rtl/sha_1_pad.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sha_1_pad.sv
// ---------------------------------------------------------------------------
// sha_1_pad : SHA-1 message padder, 32-bit word stream in, 512-bit blocks out
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha_1_pad (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] Data,
  output logic [63:0]  Index,
  output logic         Enable,
  input  logic         Ready,
  output logic         msg_done
);

  typedef enum logic [2:0] {FILL, PAD, LEN, SEND, WAIT} state_t;

  state_t        state, state_nx;
  logic [31:0]   blk_buf [16];
  logic [511:0]  blk_flat;
  logic [4:0]    wcnt;
  logic [63:0]   bitlen;
  logic          pad_done;
  logic          last_blk;
  logic          tail;       // final message word already consumed
  logic [2:0]    bytes_eff;
  logic [31:0]   last_word;
  logic          accept;
  logic          ack;
  logic          wr_en;
  logic [31:0]   wr_data;

  // Byte counts above 4 are treated as a full word.
  always_comb begin
    bytes_eff = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    case (bytes_eff)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  always_comb begin
    blk_flat = '0;
    for (int i = 0; i < 16; i++) blk_flat[511-32*i -: 32] = blk_buf[i];
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    ack      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 32'h0;
    unique case (state)
      FILL: begin
        in_ready = rst;
        if (in_valid && rst) begin
          accept  = 1'b1;
          wr_en   = 1'b1;
          wr_data = in_last ? last_word : in_data;
          if (wcnt == 5'd15) state_nx = SEND;
          else if (in_last)  state_nx = PAD;
        end
      end
      PAD: begin
        if (wcnt == 5'd14 && pad_done) begin
          state_nx = LEN;
        end else begin
          wr_en   = 1'b1;
          wr_data = pad_done ? 32'h0 : 32'h8000_0000;
          if (wcnt == 5'd15) state_nx = SEND;
        end
      end
      LEN: begin
        wr_en   = 1'b1;
        wr_data = wcnt[0] ? bitlen[31:0] : bitlen[63:32];
        if (wcnt == 5'd15) state_nx = SEND;
      end
      SEND: state_nx = WAIT;
      WAIT: begin
        if (Ready) begin
          ack = 1'b1;
          if (last_blk)  state_nx = FILL;
          else if (tail) state_nx = PAD;
          else           state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (wr_en) blk_buf[wcnt[3:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt     <= 5'd0;
      bitlen   <= 64'd0;
      pad_done <= 1'b0;
      last_blk <= 1'b0;
      tail     <= 1'b0;
      Data     <= '0;
      Index    <= 64'd0;
      Enable   <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      Enable   <= (state == SEND);
      msg_done <= 1'b0;
      if (wr_en) wcnt <= wcnt + 5'd1;
      if (accept) begin
        bitlen <= bitlen + (in_last ? {58'd0, bytes_eff, 3'd0} : 64'd32);
        if (in_last) begin
          tail     <= 1'b1;
          pad_done <= (bytes_eff != 3'd4);
        end
      end
      if (state == PAD && wr_en) pad_done <= 1'b1;
      if (state_nx == SEND && state != SEND) last_blk <= (state == LEN);
      if (state == SEND) Data <= blk_flat;
      if (ack) begin
        wcnt     <= 5'd0;
        msg_done <= last_blk;
        if (last_blk) begin
          Index    <= 64'd0;
          bitlen   <= 64'd0;
          pad_done <= 1'b0;
          tail     <= 1'b0;
        end else begin
          Index <= Index + 64'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
